// File: rtl/trap_sequencer_if.sv
// CSR write port driven by the trap sequencer towards the CSR file.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;

  modport master (output csr_we, output csr_addr, output csr_wdata);
  modport slave  (input  csr_we, input  csr_addr, input  csr_wdata);
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer: writes mepc/mcause/mstatus, then redirects fetch.
// Optional: define VECTORED_TRAP_EN to honour vectored mtvec mode for interrupts.
module trap_sequencer #(
  parameter int          XLEN         = 32,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid_e,
  input  logic             illegal_e,
  input  logic             ecall_e,
  input  logic             mret_e,
  input  logic             ext_irq,
  input  logic             timer_irq,
  input  logic [XLEN-1:0]  pc_e,
  input  logic [XLEN-1:0]  mstatus_i,
  input  logic [XLEN-1:0]  mie_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic [XLEN-1:0]  mepc_i,
  trap_sequencer_if.master csr,
  output logic             flush_o,
  output logic             stall_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    S_EPC,
    S_CAUSE,
    S_STATUS,
    S_TVEC,
    R_STATUS,
    R_EPC
  } state_t;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EXT     = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_TIMER   = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

  state_t          state_reg;
  logic [XLEN-1:0] epc_reg;
  logic [XLEN-1:0] cause_reg;
  logic            we_reg;
  logic [11:0]     addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            stall_reg;
  logic            flush_reg;
  logic            redirect_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  logic            ext_en;
  logic            timer_en;
  logic            accept;
  logic [XLEN-1:0] cause_next;
  logic [XLEN-1:0] trap_status;
  logic [XLEN-1:0] ret_status;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] tvec_target;
  logic            unused_bits;

  assign ext_en   = ext_irq   & mstatus_i[3] & mie_i[11];
  assign timer_en = timer_irq & mstatus_i[3] & mie_i[7];
  assign accept   = !reset && (state_reg == IDLE) && instr_valid_e &&
                    (illegal_e | ecall_e | mret_e | ext_en | timer_en);

  always_comb begin
    cause_next = CAUSE_TIMER;
    if (illegal_e)    cause_next = CAUSE_ILLEGAL;
    else if (ecall_e) cause_next = CAUSE_ECALL;
    else if (ext_en)  cause_next = CAUSE_EXT;
  end

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M. Return: MIE <- MPIE, MPIE <- 1.
  always_comb begin
    trap_status        = mstatus_i;
    trap_status[7]     = mstatus_i[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;
    ret_status         = mstatus_i;
    ret_status[3]      = mstatus_i[7];
    ret_status[7]      = 1'b1;
    ret_status[12:11]  = 2'b11;
  end

  assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
  logic [XLEN-1:0] vec_offset;
  assign vec_offset  = {{(XLEN-7){1'b0}}, cause_reg[4:0], 2'b00};
  assign tvec_target = ((mtvec_i[1:0] == 2'b01) && cause_reg[XLEN-1]) ?
                       (tvec_base + vec_offset) : tvec_base;
`else
  assign tvec_target = tvec_base;
`endif

  assign unused_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:0],
                         mtvec_i[1:0], mepc_i[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      epc_reg         <= '0;
      cause_reg       <= '0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      stall_reg       <= 1'b0;
      flush_reg       <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      stall_reg       <= 1'b0;
      flush_reg       <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            epc_reg   <= pc_e;
            cause_reg <= cause_next;
            we_reg    <= 1'b1;
            stall_reg <= 1'b1;
            // mret only wins when no exception is flagged alongside it
            if (!illegal_e && !ecall_e && mret_e) begin
              state_reg <= R_STATUS;
              addr_reg  <= MSTATUS_ADDR;
              wdata_reg <= ret_status;
            end else begin
              state_reg <= S_EPC;
              addr_reg  <= MEPC_ADDR;
              wdata_reg <= pc_e;
            end
          end
        end
        S_EPC: begin
          state_reg <= S_CAUSE;
          we_reg    <= 1'b1;
          stall_reg <= 1'b1;
          addr_reg  <= MCAUSE_ADDR;
          wdata_reg <= cause_reg;
        end
        S_CAUSE: begin
          state_reg <= S_STATUS;
          we_reg    <= 1'b1;
          stall_reg <= 1'b1;
          addr_reg  <= MSTATUS_ADDR;
          wdata_reg <= trap_status;
        end
        S_STATUS: begin
          state_reg       <= S_TVEC;
          flush_reg       <= 1'b1;
          redirect_reg    <= 1'b1;
          redirect_pc_reg <= tvec_target;
        end
        R_STATUS: begin
          state_reg       <= R_EPC;
          flush_reg       <= 1'b1;
          redirect_reg    <= 1'b1;
          redirect_pc_reg <= {mepc_i[XLEN-1:2], 2'b00};
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign csr.csr_we    = we_reg;
  assign csr.csr_addr  = addr_reg;
  assign csr.csr_wdata = wdata_reg;
  assign flush_o       = flush_reg | accept;
  assign stall_o       = stall_reg;
  assign redirect_o    = redirect_reg;
  assign redirect_pc_o = redirect_pc_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: per-cycle schedule model plus directed literal checks.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid_e = 1'b0;
  logic        illegal_e = 1'b0;
  logic        ecall_e = 1'b0;
  logic        mret_e = 1'b0;
  logic        ext_irq = 1'b1;
  logic        timer_irq = 1'b1;
  logic [31:0] pc_e = '0;
  logic [31:0] mstatus_i = '0;
  logic [31:0] mie_i = '0;
  logic [31:0] mtvec_i = '0;
  logic [31:0] mepc_i = '0;
  logic        flush_o, stall_o, redirect_o, busy;
  logic [31:0] redirect_pc_o;

  int checks = 0;
  int errors = 0;

  trap_sequencer_if #(.XLEN(32)) csr_bus ();

  trap_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid_e(instr_valid_e),
    .illegal_e(illegal_e), .ecall_e(ecall_e), .mret_e(mret_e),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .pc_e(pc_e),
    .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr(csr_bus), .flush_o(flush_o), .stall_o(stall_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        busy;
  } obs_t;

  // Model: an accepted event schedules the exact output tuple of every busy cycle.
  obs_t exp_q[$];

  function automatic logic m_accept();
    logic irq;
    irq = (ext_irq && mstatus_i[3] && mie_i[11]) || (timer_irq && mstatus_i[3] && mie_i[7]);
    return !reset && instr_valid_e && (illegal_e || ecall_e || mret_e || irq);
  endfunction

  function automatic obs_t mk(logic we, logic [11:0] a, logic [31:0] d, logic fl,
                              logic st, logic rd, logic [31:0] pc);
    obs_t o;
    o = '{we: we, addr: a, wdata: d, flush: fl, stall: st, redirect: rd, rpc: pc, busy: 1'b1};
    return o;
  endfunction

  always @(posedge clk) begin
    logic [31:0] cause, tgt, st;
    if (reset) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end else if (m_accept()) begin
      if (!illegal_e && !ecall_e && mret_e) begin
        st = (mstatus_i & ~32'h8) | ((mstatus_i >> 4) & 32'h8) | 32'h1880;
        exp_q.push_back(mk(1, 12'h300, st, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 12'h000, 0, 1, 0, 1, mepc_i & ~32'h3));
      end else begin
        if (illegal_e) cause = 2;
        else if (ecall_e) cause = 11;
        else if (ext_irq && mstatus_i[3] && mie_i[11]) cause = 32'h8000000B;
        else cause = 32'h80000007;
        st  = (mstatus_i & ~32'h88) | ((mstatus_i & 32'h8) << 4) | 32'h1800;
        tgt = mtvec_i & ~32'h3;
`ifdef VECTORED_TRAP_EN
        if ((mtvec_i & 32'h3) == 1 && cause >= 32'h80000000) tgt = tgt + 4 * (cause % 32);
`endif
        exp_q.push_back(mk(1, 12'h341, pc_e, 0, 1, 0, 0));
        exp_q.push_back(mk(1, 12'h342, cause, 0, 1, 0, 0));
        exp_q.push_back(mk(1, 12'h300, st, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 12'h000, 0, 1, 0, 1, tgt));
      end
    end
  end

  // Compare process plus transaction log.
  logic [43:0] wr_log[$];
  logic [31:0] last_rpc = '0;
  int          redir_cnt = 0;
  int          busy_cnt = 0;
  int          flush_cnt = 0;

  always @(negedge clk) begin
    obs_t act, exp;
    act = '{we: csr_bus.csr_we, addr: csr_bus.csr_addr, wdata: csr_bus.csr_wdata,
            flush: flush_o, stall: stall_o, redirect: redirect_o, rpc: redirect_pc_o, busy: busy};
    if (exp_q.size() > 0) exp = exp_q[0];
    else exp = '{we: 0, addr: 0, wdata: 0, flush: m_accept(), stall: 0, redirect: 0, rpc: 0, busy: 0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act, exp);
    end
    if (csr_bus.csr_we) begin
      wr_log.push_back({csr_bus.csr_addr, csr_bus.csr_wdata});
      $display("csr write addr=%h data=%h", csr_bus.csr_addr, csr_bus.csr_wdata);
    end
    if (redirect_o) begin
      redir_cnt++;
      last_rpc = redirect_pc_o;
      $display("redirect pc=%h", redirect_pc_o);
    end
    if (busy) busy_cnt++;
    if (flush_o) flush_cnt++;
  end

  task automatic chk(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller has set the event inputs; confirm the accept-cycle flush, then drop them.
  task automatic accept_pulse();
    @(negedge clk);
    chk("accept_flush", 44'(flush_o), 44'd1);
    @(posedge clk);
    #1;
    instr_valid_e = 0;
    illegal_e = 0;
    ecall_e = 0;
    mret_e = 0;
  endtask

  function automatic logic [43:0] wr(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return '1;
  endfunction

  int wb, rb, bb, fb;
  logic [31:0] vec_exp;

  initial begin
    // Reset held with interrupt lines high
    tick(1);
    @(negedge clk);
    chk("reset_outputs", {csr_bus.csr_we, csr_bus.csr_addr, flush_o, stall_o, redirect_o, busy},
        44'd0);
    chk("reset_wdata", 44'(csr_bus.csr_wdata), 44'd0);
    chk("reset_rpc", 44'(redirect_pc_o), 44'd0);
    @(posedge clk);
    #1;
    reset = 0;
    ext_irq = 0;
    timer_irq = 0;
    tick(2);

    // Illegal instruction trap
    wb = wr_log.size(); rb = redir_cnt; bb = busy_cnt;
    pc_e = 32'h100; mtvec_i = 32'h200; mstatus_i = 32'h8; mie_i = 0;
    instr_valid_e = 1; illegal_e = 1;
    accept_pulse();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) chk("illegal_busy_c4", 44'(busy), 44'd1);
      if (k == 5) chk("illegal_busy_c5", 44'(busy), 44'd0);
    end
    tick(1);
    chk("illegal_wr0", wr(wb), {12'h341, 32'h100});
    chk("illegal_wr1", wr(wb + 1), {12'h342, 32'd2});
    chk("illegal_wr2", wr(wb + 2), {12'h300, 32'h1880});
    chk("illegal_redir", 44'(last_rpc), 44'h200);
    chk("illegal_redir_cnt", 44'(redir_cnt - rb), 44'd1);
    chk("illegal_busy_cycles", 44'(busy_cnt - bb), 44'd4);

    // Timer interrupt enabled
    wb = wr_log.size();
    pc_e = 32'h40; mstatus_i = 32'h8; mie_i = 32'h80;
    instr_valid_e = 1; timer_irq = 1;
    accept_pulse();
    timer_irq = 0;
    tick(6);
    chk("timer_mepc", wr(wb), {12'h341, 32'h40});
    chk("timer_mcause", wr(wb + 1), {12'h342, 32'h80000007});

    // Timer interrupt masked by mie
    wb = wr_log.size(); fb = flush_cnt;
    mie_i = 0; instr_valid_e = 1; timer_irq = 1;
    tick(20);
    chk("timer_masked_writes", 44'(wr_log.size() - wb), 44'd0);
    chk("timer_masked_flush", 44'(flush_cnt - fb), 44'd0);
    instr_valid_e = 0; timer_irq = 0;
    tick(1);

    // Illegal, ecall-free mret and ext_irq together; ext_irq stays asserted
    wb = wr_log.size(); rb = redir_cnt;
    pc_e = 32'h180; mstatus_i = 32'h8; mie_i = 32'h800;
    instr_valid_e = 1; illegal_e = 1; mret_e = 1; ext_irq = 1;
    accept_pulse();
    instr_valid_e = 1;
    tick(3);
    mstatus_i = 32'h1880;
    tick(12);
    chk("combo_mcause", wr(wb + 1), {12'h342, 32'd2});
    chk("combo_write_cnt", 44'(wr_log.size() - wb), 44'd3);
    chk("combo_redir_cnt", 44'(redir_cnt - rb), 44'd1);
    instr_valid_e = 0; ext_irq = 0;
    tick(1);

    // mret
    wb = wr_log.size(); bb = busy_cnt;
    mstatus_i = 32'h80; mepc_i = 32'h107; pc_e = 32'h1C0;
    instr_valid_e = 1; mret_e = 1;
    accept_pulse();
    tick(3);
    chk("mret_status", wr(wb), {12'h300, 32'h1888});
    chk("mret_write_cnt", 44'(wr_log.size() - wb), 44'd1);
    chk("mret_redir", 44'(last_rpc), 44'h104);
    chk("mret_busy_cycles", 44'(busy_cnt - bb), 44'd2);

    // External interrupt with vectored mtvec
    mstatus_i = 32'h8; mie_i = 32'h800; mtvec_i = 32'h201; pc_e = 32'h500;
    instr_valid_e = 1; ext_irq = 1;
    accept_pulse();
    ext_irq = 0;
    tick(6);
`ifdef VECTORED_TRAP_EN
    vec_exp = 32'h22C;
`else
    vec_exp = 32'h200;
`endif
    chk("vector_redir", 44'(last_rpc), 44'(vec_exp));

    // Reset during S_CAUSE
    wb = wr_log.size(); rb = redir_cnt;
    mstatus_i = 32'h8; mtvec_i = 32'h200; pc_e = 32'h300;
    instr_valid_e = 1; ecall_e = 1;
    accept_pulse();
    tick(1);
    reset = 1;
    tick(1);
    reset = 0;
    @(negedge clk);
    chk("midreset_idle", 44'(busy), 44'd0);
    tick(6);
    chk("midreset_writes", 44'(wr_log.size() - wb), 44'd2);
    chk("midreset_mcause", wr(wb + 1), {12'h342, 32'd11});
    chk("midreset_redir_cnt", 44'(redir_cnt - rb), 44'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
Machine-mode trap and return sequencer for the 5-stage RV32 pipeline. It takes exception flags from the Execute-stage decode (illegal, ecall), the SYSTEM-opcode return flag, and external/timer interrupt lines. It drives the single CSR write port over a fixed multi-cycle sequence (mepc, mcause, mstatus), then stalls, flushes and redirects fetch to the trap vector or to mepc. It sits between the controller/hazard unit and the CSR file.

Parameters:
XLEN, 32, datapath/CSR width
MEPC_ADDR, 12'h341, CSR address of mepc
MCAUSE_ADDR, 12'h342, CSR address of mcause
MSTATUS_ADDR, 12'h300, CSR address of mstatus

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instr_valid_e  in  1  Execute stage holds a real (non-bubble) instruction
illegal_e  in  1  illegal instruction in Execute
ecall_e  in  1  ecall in Execute
mret_e  in  1  mret in Execute (controller return flag)
ext_irq  in  1  external interrupt, level
timer_irq  in  1  timer interrupt, level
pc_e  in  XLEN  PC of the Execute-stage instruction
mstatus_i  in  XLEN  current mstatus
mie_i  in  XLEN  current mie
mtvec_i  in  XLEN  current mtvec
mepc_i  in  XLEN  current mepc
csr_we  out  1  CSR write enable
csr_addr  out  12  CSR write address
csr_wdata  out  XLEN  CSR write data
flush_o  out  1  flush F/D/E pipeline registers
stall_o  out  1  hold PC and F/D
redirect_o  out  1  load redirect_pc_o into PC
redirect_pc_o  out  XLEN  redirect target
busy  out  1  sequencer not IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high: on reset, state=IDLE and all outputs are 0, including csr_addr, csr_wdata and redirect_pc_o.
- Event acceptance happens only in IDLE with instr_valid_e=1. Priority: illegal_e > ecall_e > mret_e > ext interrupt > timer interrupt.
- Interrupts are enabled as follows:
  - ext interrupt: ext_irq & mstatus_i[3] & mie_i[11]
  - timer interrupt: timer_irq & mstatus_i[3] & mie_i[7]
- Accept cycle:
  - flush_o=1 (combinational), so the Execute instruction does not commit.
  - Register epc=pc_e.
  - Register cause: illegal=2, ecall=11, ext=32'h8000000B, timer=32'h80000007.
- Trap path (4 cycles after accept). stall_o=1 in S_EPC, S_CAUSE and S_STATUS.
  - S_EPC: csr_we=1, addr=MEPC_ADDR, wdata=epc.
  - S_CAUSE: csr_we=1, addr=MCAUSE_ADDR, wdata=cause.
  - S_STATUS: csr_we=1, addr=MSTATUS_ADDR, wdata=mstatus_i with bit7 (MPIE)=old bit3, bit3 (MIE)=0, bits[12:11] (MPP)=2'b11.
  - S_TVEC: redirect_o=1, flush_o=1, redirect_pc_o={mtvec_i[XLEN-1:2],2'b00}; next state IDLE.
- Return path (2 cycles after accept):
  - R_STATUS: csr_we=1, stall_o=1, addr=MSTATUS_ADDR, wdata=mstatus_i with bit3=old bit7, bit7=1, MPP=2'b11.
  - R_EPC: redirect_o=1, flush_o=1, redirect_pc_o={mepc_i[XLEN-1:2],2'b00}; next state IDLE.
- busy=1 in every state except IDLE.
- csr_we is 0 in IDLE, S_TVEC and R_EPC.
- While busy, all event inputs are ignored and nothing is queued. Level interrupts are re-evaluated on return to IDLE; after a trap, MIE=0, so the same interrupt is not retaken.
- instr_valid_e=0 in IDLE: no event is accepted, even if interrupts are pending.
- Reset mid-sequence: state goes to IDLE next edge. CSR writes already issued are not undone, and no redirect is issued.
- Writes target CSRs only; the GPR file is never written.

Optional Feature:
VECTORED_TRAP_EN
- Defined: when mtvec_i[1:0]==2'b01 and cause[XLEN-1]==1, S_TVEC redirects to base + 4*cause[4:0], where base={mtvec_i[XLEN-1:2],2'b00}. Exceptions always use base.
- Undefined: mtvec mode bits are ignored and all traps go to base.

Test Plan:
- Reset held 2 cycles with irq lines high -> all outputs 0, busy=0, state IDLE.
- illegal_e at pc_e=0x100, mtvec=0x200, mstatus=0x8 -> accept cycle flush_o=1, then:
  - writes (0x341,0x100), (0x342,2), (0x300,0x1880)
  - redirect to 0x200
  - busy=0 on the 5th cycle after accept.
- timer_irq with mstatus=0x8, mie=0x80, pc_e=0x40 -> mcause=0x80000007, mepc=0x40. Same stimulus with mie=0 -> no csr_we, no flush for 20 cycles.
- illegal_e, ext_irq and mret_e together -> illegal taken, mcause=2. ext_irq ignored while busy; not retaken after return to IDLE because MIE=0.
- mret_e with mstatus=0x80, mepc=0x107 -> write (0x300,0x1888), then redirect to 0x104; busy for 2 cycles.
- VECTORED_TRAP_EN defined, mtvec=0x201, ext_irq enabled -> redirect to 0x22C. Without the macro -> 0x200.
- reset asserted in S_CAUSE -> next cycle IDLE, no mstatus write, no redirect.
